// File: rtl/mux_sel_sequencer_if.sv
// Bus between the word source, the bit-mux sequencer and the registered 16:1 mux.
// master = sequencer side; slave = upstream source plus mux side.
interface mux_sel_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] in;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  bit_valid;
  logic                  bit_last;
  logic                  busy;

  modport master (
    input  load_valid, load_data,
    output load_ready, in, sel, bit_valid, bit_last, busy
  );

  modport slave (
    output load_valid, load_data,
    input  load_ready, in, sel, bit_valid, bit_last, busy
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Word-to-bit serializer front end: latches a word, walks the mux select once per clk.
// Define MUX_SEQ_MSB_FIRST_EN to walk sel from DATA_WIDTH-1 down to 0 (default: LSB first).
module mux_sel_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int SEL_WIDTH   = 4,
  parameter int MUX_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  mux_sel_sequencer_if.master bus
);

  localparam int CNT_W = (MUX_LATENCY > 1) ? $clog2(MUX_LATENCY) : 1;

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam logic [SEL_WIDTH-1:0] FIRST = SEL_WIDTH'(DATA_WIDTH - 1);
  localparam logic [SEL_WIDTH-1:0] LAST  = '0;
`else
  localparam logic [SEL_WIDTH-1:0] FIRST = '0;
  localparam logic [SEL_WIDTH-1:0] LAST  = SEL_WIDTH'(DATA_WIDTH - 1);
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] word;
  logic [SEL_WIDTH-1:0]  sel;
  logic [CNT_W-1:0]      cnt;
  logic                  ready;
  logic                  issue;
  logic                  issue_last;
  logic [MUX_LATENCY-1:0] vld_p;
  logic [MUX_LATENCY-1:0] last_p;

  function automatic logic [SEL_WIDTH-1:0] step_sel(input logic [SEL_WIDTH-1:0] s);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return s - SEL_WIDTH'(1);
`else
    return s + SEL_WIDTH'(1);
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.load_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        issue      = 1'b1;
        issue_last = (sel == LAST);
        if (sel == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word/select registers: sel stops on LAST and holds there through DRAIN and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      sel  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            word <= bus.load_data;
            sel  <= FIRST;
          end
        end
        SHIFT: begin
          if (sel != LAST) sel <= step_sel(sel);
          else             cnt <= CNT_W'(MUX_LATENCY - 1);
        end
        DRAIN: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Issue pipe p0..p(MUX_LATENCY-1): matches the mux register depth so flags line up with its output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      vld_p[0]  <= issue;
      last_p[0] <= issue_last;
      for (int i = 1; i < MUX_LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
      end
    end
  end

  assign bus.load_ready = ready;
  assign bus.busy       = (state != IDLE);
  assign bus.in         = word;
  assign bus.sel        = sel;
  assign bus.bit_valid  = vld_p[MUX_LATENCY-1];
  assign bus.bit_last   = last_p[MUX_LATENCY-1];

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer paired with a registered 16:1 bit mux model.
// Honors MUX_SEQ_MSB_FIRST_EN the same way as the design.
module tb_mux_sel_sequencer;
  localparam int DW = 16;
  localparam int SW = 4;
  localparam int L  = 1;

  logic clk = 1'b0;
  logic rst;
  logic mux_out;
  always #5 clk = ~clk;

  mux_sel_sequencer_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  mux_sel_sequencer #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .MUX_LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered bit mux downstream of the sequencer
  always @(posedge clk) mux_out <= bus.in[bus.sel];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: everything follows from the offset d of the current cycle from the last handshake edge.
  function automatic int idx(input int k);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return DW - 1 - k;
`else
    return k;
`endif
  endfunction

  int            cyc = 0;
  int            hs  = 0;
  bit            has_word = 1'b0;
  logic [DW-1:0] m_word = '0;

  function automatic bit m_ready(input int t);
    return !has_word || (t - hs) >= DW + L;
  endfunction

  always @(posedge clk) begin
    bit rdy;
    rdy = m_ready(cyc);
    cyc++;
    if (rst) has_word = 1'b0;
    else if (bus.load_valid && rdy) begin
      hs       = cyc;
      m_word   = bus.load_data;
      has_word = 1'b1;
    end
  end

  always @(negedge clk) begin
    int   d;
    logic e_rdy, e_vld, e_last;
    logic [DW-1:0] e_in;
    int   e_sel;
    if (chk_en) begin
      if (!has_word) begin
        e_rdy = 1'b1; e_vld = 1'b0; e_last = 1'b0; e_in = '0; e_sel = 0;
        d = 0;
      end else begin
        d      = cyc - hs;
        e_rdy  = (d >= DW + L);
        e_vld  = (d >= L) && (d <= L + DW - 1);
        e_last = (d == L + DW - 1);
        e_in   = m_word;
        e_sel  = idx((d < DW - 1) ? d : DW - 1);
      end
      chk("load_ready", 32'(bus.load_ready), 32'(e_rdy));
      chk("busy", 32'(bus.busy), 32'(!e_rdy));
      chk("sel", 32'(bus.sel), 32'(e_sel));
      chk("in", 32'(bus.in), 32'(e_in));
      chk("bit_valid", 32'(bus.bit_valid), 32'(e_vld));
      chk("bit_last", 32'(bus.bit_last), 32'(e_last));
      if (e_vld) chk("mux_out", 32'(mux_out), 32'(m_word[idx(d - L)]));
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] stream; // stream[k] = k-th bit out of the mux
  } vec_t;

  task automatic wait_idle();
    int n = 0;
    while (!bus.load_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(bus.load_ready), 32'd1);
  endtask

  task automatic run_word(input logic [DW-1:0] data, input logic [DW-1:0] stream);
    logic [DW-1:0] got = '0;
    int k = 0, lastcnt = 0, lastpos = -1;
    wait_idle();
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int c = 0; c < DW + L + 6; c++) begin
      if (bus.bit_valid) begin
        if (k < DW) got[k] = mux_out;
        if (bus.bit_last) begin lastcnt++; lastpos = k; end
        k++;
      end
      @(negedge clk);
    end
    chk("vec_count", 32'(k), 32'(DW));
    chk("vec_stream", 32'(got), 32'(stream));
    chk("vec_last_cnt", 32'(lastcnt), 32'd1);
    chk("vec_last_pos", 32'(lastpos), 32'(DW - 1));
  endtask

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lastseen;
`ifdef MUX_SEQ_MSB_FIRST_EN
    vecs[0] = '{16'h0059, 16'h9A00};
    vecs[1] = '{16'h8001, 16'h8001};
    vecs[2] = '{16'hAAAA, 16'h5555};
    vecs[3] = '{16'h1234, 16'h2C48};
    vecs[4] = '{16'hFFFF, 16'hFFFF};
`else
    vecs[0] = '{16'h0059, 16'h0059};
    vecs[1] = '{16'h8001, 16'h8001};
    vecs[2] = '{16'hAAAA, 16'hAAAA};
    vecs[3] = '{16'h1234, 16'h1234};
    vecs[4] = '{16'hFFFF, 16'hFFFF};
`endif
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_in", 32'(bus.in), 32'd0);
    chk("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
    chk_en = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_word(vecs[i].data, vecs[i].stream);

    // Back-to-back: valid held high, second word waits for load_ready
    wait_idle();
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hFFFF;
    @(negedge clk);
    bus.load_data = 16'h0000;
    n = 0;
    while (!bus.load_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready_return", 32'(n), 32'(DW + L));
    @(negedge clk);
    chk("b2b_second_in", 32'(bus.in), 32'h0000);
    chk("b2b_second_busy", 32'(bus.busy), 32'd1);
    bus.load_valid = 1'b0;

    // Load while busy is ignored
    wait_idle();
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h1234;
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hAAAA;
    @(negedge clk);
    bus.load_valid = 1'b0;
    chk("busy_load_in", 32'(bus.in), 32'h1234);
    repeat (DW) @(negedge clk);
    chk("busy_load_in_end", 32'(bus.in), 32'h1234);

    // Reset mid-word when sel reaches 7
    wait_idle();
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h00F0;
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (7) @(negedge clk);
`ifndef MUX_SEQ_MSB_FIRST_EN
    chk("midrst_sel_before", 32'(bus.sel), 32'd7);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_sel", 32'(bus.sel), 32'd0);
    chk("midrst_in", 32'(bus.in), 32'd0);
    chk("midrst_bit_valid", 32'(bus.bit_valid), 32'd0);
    chk("midrst_load_ready", 32'(bus.load_ready), 32'd1);
    lastseen = 0;
    repeat (DW + 4) begin
      if (bus.bit_last) lastseen++;
      @(negedge clk);
    end
    chk("midrst_no_last", 32'(lastseen), 32'd0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      bus.load_valid = ($urandom_range(0, 2) == 0);
      bus.load_data  = DW'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.load_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
